uart_core_ext: RTL
==================

# uart_core_ext

Parametrised successor to the UART core. Sits behind the UART software-register block and drives the RS-232 pins. Adds:
- configurable character width
- runtime-selectable parity and 1/2 stop bits
- an RX FIFO with level reporting
- sticky parity, framing and overrun error flags
- RTS flow control driven by FIFO occupancy

## Interface
- DATA_W, 8, character width in bits, legal 5..9
- DIV_W, 16, width of bit_duration_i
- RX_FIFO_DEPTH, 4, RX FIFO entries, power of 2, ≥2
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- rst_soft_i  in  1  software reset, synchronous, active-high, same effect as rst_i
- tx_en_i  in  1  transmitter enable
- rx_en_i  in  1  receiver enable
- parity_i  in  2  0/3 none, 1 even, 2 odd
- stop2_i  in  1  1 = two stop bits on TX
- bit_duration_i  in  DIV_W  clock cycles per bit, ≥4, static while either side is busy
- data_write_en_i  in  1  TX write strobe
- tx_data_i  in  DATA_W  character to send
- tx_ready_o  out  1  TX accepts a write this cycle
- data_read_en_i  in  1  RX FIFO pop strobe
- rx_data_o  out  DATA_W  FIFO head (show-ahead)
- rx_ready_o  out  1  FIFO not empty
- rx_level_o  out  $clog2(RX_FIFO_DEPTH)+1  FIFO occupancy
- parity_err_o, frame_err_o, overrun_o  out  1 each  sticky error flags
- err_clr_i  in  1  clears all three error flags
- rxd_i  in  1  serial in, asynchronous
- txd_o  out  1  serial out
- cts_i  in  1  peer ready, active-high
- rts_o  out  1  ready to receive, active-high

## Operation
- Reset (rst_i or rst_soft_i), applied at a clock edge:
  - outputs: txd_o=1, tx_ready_o=0, rts_o=0, rx_ready_o=0, rx_data_o=0, rx_level_o=0, all error flags 0.
  - both FSMs go to IDLE and the FIFO is flushed.
  - Reset mid-frame aborts the frame; txd_o=1 the next cycle.
- Frame format: start bit (0), then DATA_W data bits LSB first, then the parity bit if enabled, then the stop bits (1). Every bit lasts bit_duration_i cycles.
- TX FSM states: IDLE → START → DATA → PARITY (skipped if parity off) → STOP1 → STOP2 (only if stop2_i) → IDLE.
  - tx_ready_o = tx_en_i & IDLE & cts_i.
  - A write while tx_ready_o=0 is ignored.
  - parity_i and stop2_i are latched at the accepted write.
  - Dropping tx_en_i or cts_i mid-frame does not abort the frame; it completes.
- RX input: rxd_i passes through a 2-flop synchroniser.
- RX FSM states: IDLE → START → DATA → PARITY (skipped if parity off) → STOP → IDLE.
  - In IDLE with rx_en_i=1, a synchronised 1→0 transition enters START. parity_i is latched at that point.
  - Each bit is sampled at a counter value of bit_duration_i/2 (floor).
  - Start sample =1: false start, return to IDLE, nothing pushed.
  - Parity mismatch: set parity_err_o.
  - Stop sample =0: set frame_err_o.
  - The character is pushed at the stop-bit sample regardless of errors.
  - RX always checks exactly one stop bit; a second stop bit is received as idle line.
  - rx_en_i=0 forces IDLE the next cycle and discards the partial character.
- FIFO:
  - Push when full, with no pop in the same cycle: the character is dropped and overrun_o is set.
  - Push and pop in the same cycle when full: both succeed, no overrun.
  - Pop when empty: ignored.
- rts_o = rx_en_i & (rx_level_o < RX_FIFO_DEPTH).
- Error flags are sticky. err_clr_i clears them. If a set event and err_clr_i coincide, the set wins.

## Timing
- TX write accepted at edge N:
  - txd_o=0 and tx_ready_o=0 from N+1.
  - Each bit holds for exactly bit_duration_i cycles.
  - tx_ready_o may reassert from the cycle after the final stop bit ends.
  - Frame length = (1 + DATA_W + P + S)·bit_duration_i cycles, where P∈{0,1} and S∈{1,2}.
- RX start detect: 2 cycles after the rxd_i falling edge (synchroniser delay).
- rx_ready_o and the incremented rx_level_o appear the cycle after the stop-bit sample edge.
- Pop at edge M: rx_data_o shows the next entry and rx_level_o decrements at M+1.
- Error flags assert the cycle after the sample edge that detected the error.

## Test plan
- Loopback (txd_o→rxd_i, rts_o→cts_i), DATA_W=8, no parity, 1 stop, div=100, send 0x00..0xFF one at a time → each read equals the sent value, no error flags.
- parity_i=1 (even), send 0x5A and 0x01 → txd_o parity bits are 0 then 1; received data matches, parity_err_o=0. Repeat with parity_i=2 (odd) → parity bits inverted.
- Bench drives rxd_i with 0xA5, parity_i=1, wrong parity bit → rx_data_o=0xA5, parity_err_o=1. Pulse err_clr_i → flag 0.
- Depth 4, bench drives 5 characters on rxd_i without popping:
  - after 4: rx_level_o=4, rts_o=0.
  - after 5: overrun_o=1, level stays 4, reads return characters 1..4 in order.
- rxd_i glitch low for bit_duration_i/4 cycles → no push, no frame_err_o. A stop bit driven 0 → frame_err_o=1, character pushed.
- rst_soft_i mid-TX frame with the FIFO holding 2 entries → next cycle txd_o=1, rx_level_o=0, rx_ready_o=0, flags 0, tx_ready_o=1 (with tx_en_i=1, cts_i=1).

Source files
------------

// File: rtl/uart_core_ext.sv
// uart_core_ext: UART with configurable width, parity, 1/2 stop bits,
// RX FIFO with level, sticky error flags and RTS/CTS flow control.
module uart_core_ext #(
  parameter int DATA_W        = 8,
  parameter int DIV_W         = 16,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             rst_soft_i,
  input  logic                             tx_en_i,
  input  logic                             rx_en_i,
  input  logic [1:0]                       parity_i,
  input  logic                             stop2_i,
  input  logic [DIV_W-1:0]                 bit_duration_i,
  input  logic                             data_write_en_i,
  input  logic [DATA_W-1:0]                tx_data_i,
  output logic                             tx_ready_o,
  input  logic                             data_read_en_i,
  output logic [DATA_W-1:0]                rx_data_o,
  output logic                             rx_ready_o,
  output logic [$clog2(RX_FIFO_DEPTH):0]   rx_level_o,
  output logic                             parity_err_o,
  output logic                             frame_err_o,
  output logic                             overrun_o,
  input  logic                             err_clr_i,
  input  logic                             rxd_i,
  output logic                             txd_o,
  input  logic                             cts_i,
  output logic                             rts_o
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(RX_FIFO_DEPTH);

  logic rst;
  assign rst = rst_i | rst_soft_i;

  logic [DIV_W-1:0] div_half;
  logic [DIV_W-1:0] div_last;
  assign div_half = bit_duration_i >> 1;
  assign div_last = bit_duration_i - 1'b1;

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2
  } tx_st_t;

  tx_st_t            tx_st;
  logic [DIV_W-1:0]  tx_cnt;
  logic [IW-1:0]     tx_idx;
  logic [DATA_W-1:0] tx_sh;
  logic              tx_pbit;
  logic              tx_pen;
  logic              tx_s2;
  logic              tx_end;

  assign tx_end = (tx_cnt == div_last);
  assign tx_ready_o = tx_en_i & cts_i & (tx_st == T_IDLE) & ~rst;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      tx_st   <= T_IDLE;
      txd_o   <= 1'b1;
      tx_cnt  <= '0;
      tx_idx  <= '0;
      tx_sh   <= '0;
      tx_pbit <= 1'b0;
      tx_pen  <= 1'b0;
      tx_s2   <= 1'b0;
    end else begin
      tx_cnt <= tx_end ? '0 : tx_cnt + 1'b1;
      case (tx_st)
        T_IDLE: begin
          tx_cnt <= '0;
          txd_o  <= 1'b1;
          if (data_write_en_i && tx_ready_o) begin
            tx_st   <= T_START;
            txd_o   <= 1'b0;
            tx_sh   <= tx_data_i;
            tx_pen  <= parity_i[0] ^ parity_i[1];
            tx_pbit <= (^tx_data_i) ^ (parity_i == 2'd2);
            tx_s2   <= stop2_i;
          end
        end
        T_START: begin
          if (tx_end) begin
            tx_st  <= T_DATA;
            txd_o  <= tx_sh[0];
            tx_sh  <= tx_sh >> 1;
            tx_idx <= '0;
          end
        end
        T_DATA: begin
          if (tx_end) begin
            if (tx_idx == LAST) begin
              if (tx_pen) begin
                tx_st <= T_PAR;
                txd_o <= tx_pbit;
              end else begin
                tx_st <= T_STOP1;
                txd_o <= 1'b1;
              end
            end else begin
              txd_o  <= tx_sh[0];
              tx_sh  <= tx_sh >> 1;
              tx_idx <= tx_idx + 1'b1;
            end
          end
        end
        T_PAR: begin
          if (tx_end) begin
            tx_st <= T_STOP1;
            txd_o <= 1'b1;
          end
        end
        T_STOP1: begin
          if (tx_end) tx_st <= tx_s2 ? T_STOP2 : T_IDLE;
        end
        T_STOP2: begin
          if (tx_end) tx_st <= T_IDLE;
        end
        default: tx_st <= T_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  // sync[1] is the synchronised line, sync[2] its previous value
  logic [2:0] sync;
  logic       rxs;
  logic       fall;

  always_ff @(posedge clk_i) begin
    if (rst) sync <= 3'b111;
    else     sync <= {sync[1:0], rxd_i};
  end

  assign rxs  = sync[1];
  assign fall = sync[2] & ~sync[1];

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP
  } rx_st_t;

  rx_st_t            rx_st;
  logic [DIV_W-1:0]  rx_cnt;
  logic [IW-1:0]     rx_idx;
  logic [DATA_W-1:0] rx_sh;
  logic              rx_par;
  logic              rx_pen;
  logic              rx_odd;
  logic              rx_smp;
  logic              rx_end;

  assign rx_smp = (rx_cnt == div_half);
  assign rx_end = (rx_cnt == div_last);

  always_ff @(posedge clk_i) begin
    if (rst) begin
      rx_st  <= R_IDLE;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh  <= '0;
      rx_par <= 1'b0;
      rx_pen <= 1'b0;
      rx_odd <= 1'b0;
    end else if (!rx_en_i) begin
      rx_st  <= R_IDLE;
      rx_cnt <= '0;
    end else begin
      rx_cnt <= rx_end ? '0 : rx_cnt + 1'b1;
      case (rx_st)
        R_IDLE: begin
          rx_cnt <= '0;
          if (fall) begin
            rx_st  <= R_START;
            rx_idx <= '0;
            rx_par <= 1'b0;
            rx_pen <= parity_i[0] ^ parity_i[1];
            rx_odd <= (parity_i == 2'd2);
          end
        end
        R_START: begin
          if (rx_smp && rxs) begin
            rx_st  <= R_IDLE;
            rx_cnt <= '0;
          end else if (rx_end) begin
            rx_st <= R_DATA;
          end
        end
        R_DATA: begin
          if (rx_smp) begin
            rx_sh  <= {rxs, rx_sh[DATA_W-1:1]};
            rx_par <= rx_par ^ rxs;
          end
          if (rx_end) begin
            if (rx_idx == LAST) rx_st <= rx_pen ? R_PAR : R_STOP;
            else                rx_idx <= rx_idx + 1'b1;
          end
        end
        R_PAR: begin
          if (rx_end) rx_st <= R_STOP;
        end
        R_STOP: begin
          // leave at the stop sample so a back-to-back start is caught
          if (rx_smp) begin
            rx_st  <= R_IDLE;
            rx_cnt <= '0;
          end
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  logic push;
  logic perr_set;
  logic ferr_set;

  assign push     = rx_en_i & (rx_st == R_STOP) & rx_smp;
  assign ferr_set = push & ~rxs;
  assign perr_set = rx_en_i & (rx_st == R_PAR) & rx_smp &
                    (rxs != (rx_par ^ rx_odd));

  // ---------------- RX FIFO ----------------
  logic [DATA_W-1:0] mem [RX_FIFO_DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [AW:0]       cnt;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push_ok;
  logic              ovr_set;

  assign full    = (cnt == FULL_LVL);
  assign empty   = (cnt == '0);
  assign pop     = data_read_en_i & ~empty;
  assign push_ok = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (push_ok && !rst) mem[wp] <= rx_sh;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rx_data_o  = empty ? '0 : mem[rp];
  assign rx_ready_o = ~empty;
  assign rx_level_o = cnt;
  assign rts_o      = rx_en_i & ~full & ~rst;

  // ---------------- sticky error flags ----------------
  always_ff @(posedge clk_i) begin
    if (rst) begin
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      parity_err_o <= perr_set | (parity_err_o & ~err_clr_i);
      frame_err_o  <= ferr_set | (frame_err_o & ~err_clr_i);
      overrun_o    <= ovr_set | (overrun_o & ~err_clr_i);
    end
  end

endmodule
